// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - TOS-register stack controller driving an external SP-stepped stack
//
// Keeps the top-of-stack word in a local register and the remaining elements
// in an attached stack whose registered read port (stk_Q) presents NOS.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   op_valid/op/op_data        operation request: 00 NOP, 01 PUSH, 10 POP, 11 REPLACE NOS
//   op_ready                   high in IDLE; op accepted when op_valid && op_ready
//   tos, nos, nos_valid        top of stack, next on stack (stk_Q), NOS qualifier
//   depth, empty, full         element count including TOS and its bounds
//   err_overflow/underflow     sticky error flags, cleared by err_clear
//   stk_D/dec/change/update    attached stack write data and SP controls
//   stk_Q                      attached stack registered read data
module stack_ctrl #(
    parameter int saddr_width = 8,
    parameter int width       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   op_valid,
    input  logic [1:0]             op,
    input  logic [width-1:0]       op_data,
    output logic                   op_ready,
    output logic [width-1:0]       tos,
    output logic [width-1:0]       nos,
    output logic                   nos_valid,
    output logic [saddr_width:0]   depth,
    output logic                   empty,
    output logic                   full,
    output logic                   err_overflow,
    output logic                   err_underflow,
    input  logic                   err_clear,
    output logic [width-1:0]       stk_D,
    output logic                   stk_dec,
    output logic                   stk_change,
    output logic                   stk_update,
    input  logic [width-1:0]       stk_Q
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIX    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [1:0] OP_PUSH    = 2'b01;
    localparam logic [1:0] OP_POP     = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;

    localparam logic [saddr_width:0] DEPTH_ZERO = '0;
    localparam logic [saddr_width:0] DEPTH_ONE  = {{saddr_width{1'b0}}, 1'b1};
    localparam logic [saddr_width:0] DEPTH_MAX  = {1'b1, {saddr_width{1'b0}}};

    state_t                 state_q, state_d;
    logic [width-1:0]       tos_q, tos_d;
    logic [saddr_width:0]   depth_q, depth_d;
    logic                   err_overflow_q, err_overflow_d;
    logic                   err_underflow_q, err_underflow_d;

    logic accept;
    logic is_push, is_pop, is_repl;
    logic push_first, push_stack, push_ovf;
    logic pop_last, pop_stack, pop_unf;
    logic repl_ok, repl_unf;
    logic depth_ge2;

    // Operation decode; only meaningful in IDLE, so every term includes accept.
    assign accept    = op_valid && (state_q == IDLE);
    assign is_push   = accept && (op == OP_PUSH);
    assign is_pop    = accept && (op == OP_POP);
    assign is_repl   = accept && (op == OP_REPLACE);
    assign depth_ge2 = (depth_q > DEPTH_ONE);

    assign push_first = is_push && (depth_q == DEPTH_ZERO);
    assign push_stack = is_push && (depth_q != DEPTH_ZERO) && (depth_q != DEPTH_MAX);
    assign push_ovf   = is_push && (depth_q == DEPTH_MAX);
    assign pop_last   = is_pop && (depth_q == DEPTH_ONE);
    assign pop_stack  = is_pop && depth_ge2;
    assign pop_unf    = is_pop && (depth_q == DEPTH_ZERO);
    assign repl_ok    = is_repl && depth_ge2;
    assign repl_unf   = is_repl && !depth_ge2;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (pop_stack) begin
                    state_d = FIX;
                end else if (push_stack || repl_ok) begin
                    state_d = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            FIX:     state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: stack controls are purely combinational from the FSM and decode.
    always_comb begin
        stk_D      = '0;
        stk_dec    = 1'b0;
        stk_change = 1'b0;
        stk_update = 1'b0;
        case (state_q)
            IDLE: begin
                if (push_stack) begin
                    stk_change = 1'b1;
                    stk_D      = tos_q;
                end else if (pop_stack) begin
                    // The SP step writes stk_D into the new NOS slot; FIX repairs it.
                    stk_change = 1'b1;
                    stk_dec    = 1'b1;
                end else if (repl_ok) begin
                    stk_update = 1'b1;
                    stk_D      = op_data;
                end
            end
            FIX: begin
                // stk_Q holds the pre-write NOS captured on the POP edge.
                stk_update = 1'b1;
                stk_D      = stk_Q;
            end
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        tos_d   = tos_q;
        depth_d = depth_q;
        if (push_first || push_stack) begin
            tos_d   = op_data;
            depth_d = depth_q + DEPTH_ONE;
        end else if (pop_last) begin
            tos_d   = '0;
            depth_d = DEPTH_ZERO;
        end else if (pop_stack) begin
            tos_d   = stk_Q;
            depth_d = depth_q - DEPTH_ONE;
        end
        // A fresh error in the same cycle as err_clear keeps the flag set.
        err_overflow_d  = push_ovf || (err_overflow_q && !err_clear);
        err_underflow_d = pop_unf || repl_unf || (err_underflow_q && !err_clear);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tos_q           <= '0;
            depth_q         <= '0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            tos_q           <= tos_d;
            depth_q         <= depth_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign op_ready      = (state_q == IDLE);
    assign tos           = tos_q;
    assign nos           = stk_Q;
    assign nos_valid     = (state_q == IDLE) && depth_ge2;
    assign depth         = depth_q;
    assign empty         = (depth_q == DEPTH_ZERO);
    assign full          = (depth_q == DEPTH_MAX);
    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - directed self-checking bench for stack_ctrl with a behavioural stack
module tb_stack_ctrl;

    localparam int SAW = 2;
    localparam int W   = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           op_valid;
    logic [1:0]     op;
    logic [W-1:0]   op_data;
    logic           op_ready;
    logic [W-1:0]   tos;
    logic [W-1:0]   nos;
    logic           nos_valid;
    logic [SAW:0]   depth;
    logic           empty;
    logic           full;
    logic           err_overflow;
    logic           err_underflow;
    logic           err_clear;
    logic [W-1:0]   stk_D;
    logic           stk_dec;
    logic           stk_change;
    logic           stk_update;
    logic [W-1:0]   stk_Q;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] iss_D;
    logic         iss_chg, iss_dec, iss_upd;

    always #5 clk = ~clk;

    stack_ctrl #(.saddr_width(SAW), .width(W)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_data(op_data),
        .op_ready(op_ready), .tos(tos), .nos(nos), .nos_valid(nos_valid),
        .depth(depth), .empty(empty), .full(full),
        .err_overflow(err_overflow), .err_underflow(err_underflow), .err_clear(err_clear),
        .stk_D(stk_D), .stk_dec(stk_dec), .stk_change(stk_change),
        .stk_update(stk_update), .stk_Q(stk_Q)
    );

    // Behavioural stack: SP steps by change/dec, write lands at the new SP,
    // read port registers the pre-write word at the new SP.
    logic [W-1:0]   mem [0:(1<<SAW)-1];
    logic [SAW-1:0] sp;
    logic [SAW-1:0] sp_n;
    assign sp_n = stk_change ? (stk_dec ? sp - 1'b1 : sp + 1'b1) : sp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp    <= '0;
            stk_Q <= '0;
        end else begin
            if (stk_change || stk_update) mem[sp_n] <= stk_D;
            stk_Q <= mem[sp_n];
            sp    <= sp_n;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge with op_ready high; returns at the negedge where op_ready is high again.
    task automatic issue(input string tag, input logic [1:0] o, input logic [W-1:0] d, input int exp_lat);
        int lat;
        bit done;
        op_valid = 1'b1;
        op       = o;
        op_data  = d;
        #1;
        iss_D   = stk_D;
        iss_chg = stk_change;
        iss_dec = stk_dec;
        iss_upd = stk_update;
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
        op        = 2'b00;
        op_data   = '0;
        err_clear = 1'b0;
        lat  = 1;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (op_ready) done = 1;
            else lat++;
        end
        check({tag, "_lat"}, done ? lat : 99, exp_lat);
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; op = 2'b00; op_data = '0; err_clear = 1'b0;
        #1;
        check("rst_ready", op_ready, 1);
        check("rst_tos", tos, 0);
        check("rst_depth", depth, 0);
        check("rst_flags", {empty, full, nos_valid, err_overflow, err_underflow}, 5'b10000);
        check("rst_stk", {stk_change, stk_update, stk_dec}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Push sequence
        issue("push1", 2'b01, 16'h1111, 1);
        check("push1_acc", {iss_chg, iss_upd}, 0);
        check("push1_tos", tos, 16'h1111);
        check("push1_nosv", nos_valid, 0);
        issue("push2", 2'b01, 16'h2222, 2);
        check("push2_acc", {iss_chg, iss_dec, iss_D}, {2'b10, 16'h1111});
        issue("push3", 2'b01, 16'h3333, 2);
        check("push3_tos", tos, 16'h3333);
        check("push3_depth", depth, 3);
        check("push3_nos", {nos_valid, nos}, {1'b1, 16'h2222});

        // POP twice
        issue("pop1", 2'b10, 16'h0, 3);
        check("pop1_acc", {iss_chg, iss_dec, iss_D}, {2'b11, 16'h0000});
        check("pop1_tos", tos, 16'h2222);
        check("pop1_nos", {nos_valid, nos}, {1'b1, 16'h1111});
        check("pop1_depth", depth, 2);
        issue("pop2", 2'b10, 16'h0, 3);
        check("pop2_tos", tos, 16'h1111);
        check("pop2_depth", depth, 1);
        check("pop2_nosv", nos_valid, 0);

        // REPLACE at depth 3
        issue("push4", 2'b01, 16'h2222, 2);
        issue("push5", 2'b01, 16'h3333, 2);
        issue("repl", 2'b11, 16'hABCD, 2);
        check("repl_acc", {iss_upd, iss_chg, iss_D}, {2'b10, 16'hABCD});
        check("repl_nos", nos, 16'hABCD);
        check("repl_tos", tos, 16'h3333);
        check("repl_depth", depth, 3);
        issue("pop3", 2'b10, 16'h0, 3);
        check("pop3_tos", tos, 16'hABCD);
        check("pop3_nos", nos, 16'h1111);
        issue("pop4", 2'b10, 16'h0, 3);
        issue("pop5", 2'b10, 16'h0, 1);
        check("pop5_tos", tos, 0);
        check("pop5_empty", {empty, depth}, {1'b1, 3'd0});

        // Underflow cases
        issue("popunf", 2'b10, 16'h0, 1);
        check("popunf_acc", {iss_chg, iss_upd}, 0);
        check("popunf_err", {err_underflow, depth}, {1'b1, 3'd0});
        err_clear = 1'b1;
        issue("clrpop", 2'b10, 16'h0, 1);
        check("clrpop_err", err_underflow, 1);
        issue("push6", 2'b01, 16'h7777, 1);
        issue("replunf", 2'b11, 16'h1234, 1);
        check("replunf_tos", {tos, depth}, {16'h7777, 3'd1});
        issue("pop6", 2'b10, 16'h0, 1);

        // Overflow with 2-bit stack
        issue("fill1", 2'b01, 16'h0001, 1);
        issue("fill2", 2'b01, 16'h0002, 2);
        issue("fill3", 2'b01, 16'h0003, 2);
        issue("fill4", 2'b01, 16'h0004, 2);
        issue("fill5", 2'b01, 16'h0005, 1);
        check("fill5_acc", {iss_chg, iss_upd}, 0);
        check("fill5_depth", {full, depth}, {1'b1, 3'd4});
        check("fill5_tos", tos, 16'h0004);
        check("fill5_nos", nos, 16'h0003);
        check("fill5_err", {err_overflow, err_underflow}, 2'b11);
        issue("nop", 2'b00, 16'hFFFF, 1);
        check("nop_state", {tos, depth}, {16'h0004, 3'd4});
        err_clear = 1'b1;
        @(posedge clk);
        #1 err_clear = 1'b0;
        @(negedge clk);
        check("clr_err", {err_overflow, err_underflow}, 2'b00);

        // Reset during FIX
        op_valid = 1'b1; op = 2'b10;
        @(posedge clk);
        #1 op_valid = 1'b0; op = 2'b00;
        @(negedge clk);
        check("fix_ctl", {op_ready, stk_update, stk_change}, 3'b010);
        check("fix_D", stk_D, 16'h0002);
        #2 reset = 1'b1;
        #1;
        check("arst_ctl", {op_ready, stk_update, stk_change, stk_dec}, 4'b1000);
        check("arst_state", {tos, depth, empty, full, nos_valid}, {16'h0, 3'd0, 3'b100});
        @(negedge clk);
        reset = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                seen = seen | stk_change | stk_update | ~op_ready;
            end
            check("arst_quiet", seen, 0);
        end
        issue("push_after", 2'b01, 16'h5555, 1);
        check("after_tos", {tos, depth}, {16'h5555, 3'd1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
